ysyx_23060136_exu_div_ctrl: RTL
===============================

// Module: ysyx_23060136_exu_div_ctrl
// PURPOSE
// - EXU-side initiator for the iterative divider; decodes RV64M DIV/DIVU/REM/REMU[W] requests from issue.
// - Handles div-by-zero and signed overflow locally; issues all other ops to the divider over its handshake.
// - Holds divider operands stable, captures the one-cycle result pulse, selects/sign-extends the result.
// - Presents the result downstream with valid/ready back-pressure. Sits between EXU issue and WB mux.
// PARAMETERS
// - XLEN   64  operand/result width
// - TAG_W  5   rd tag carried alongside request
// PORTS
// - clk            in   1      clock
// - rst            in   1      reset; synchronous, active-high
// - in_valid       in   1      request valid
// - in_ready       out  1      request accepted when in_valid&in_ready
// - in_op          in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU
// - in_word        in   1      1 = *W variant (32-bit operands, sext result)
// - in_rs1         in   XLEN   dividend
// - in_rs2         in   XLEN   divisor
// - in_tag         in   TAG_W  rd tag
// - flush          in   1      pipeline kill; discard in-flight op
// - out_valid      out  1      result valid
// - out_ready      in   1      downstream accepts
// - out_data       out  XLEN   result
// - out_tag        out  TAG_W  tag of result
// - div_valid      out  1      request to divider
// - div_ready      in   1      divider idle
// - div_dividend   out  XLEN   held from issue through result pulse
// - div_divisor    out  XLEN   held from issue through result pulse
// - div_w          out  1      held, = in_word
// - div_signed     out  1      held, = ~in_op[0]
// - div_out_valid  in   1      one-cycle result pulse (no back-pressure)
// - div_quotient   in   XLEN   valid only when div_out_valid
// - div_remainder  in   XLEN   valid only when div_out_valid
// BEHAVIOUR
// - Reset: state IDLE; in_ready=1; out_valid=0, out_data=0, out_tag=0, div_valid=0; operand regs 0.
// - FSM IDLE -> (accept, special) DONE | (accept, normal) ISSUE; ISSUE -> WAIT when div_valid&div_ready.
// - WAIT -> DONE on div_out_valid; DONE -> IDLE on out_ready. in_ready=1 only in IDLE.
// - Accept latches op/word/rs1/rs2/tag into regs; div_* outputs are driven only from these regs.
// - div_valid=1 only in ISSUE; held until div_ready.
// - Special (W: compare low 32 bits): divisor==0 -> DIV* = all ones, REM* = dividend.
// - Special: signed and dividend==MIN and divisor==-1 -> DIV = dividend, REM = 0 (W: MIN=0x8000_0000).
// - Special result: out_valid in cycle after accept; divider never started.
// - Normal: on div_out_valid, capture quotient (op[1]=0) or remainder (op[1]=1).
// - W result: out_data = sext(sel[31:0]); non-W: sel[63:0]. Special results obey same W sext rule.
// - out_valid/out_data/out_tag stable while out_valid&~out_ready.
// - Latency with team divider (64-bit mode): accept T, div accepted T+1, pulse T+66, out_valid T+67.
// - W: pulse T+34, out_valid T+35. Generally out_valid = cycle after div_out_valid.
// - flush in IDLE/DONE/ISSUE (before div handshake): -> IDLE, out_valid=0, nothing issued.
// - flush same cycle as ISSUE handshake or in WAIT: -> DRAIN; in_ready=0; stay until div_out_valid, discard, -> IDLE.
// - flush and in_valid same cycle in IDLE: flush wins, no accept.
// - div_out_valid outside WAIT/DRAIN: ignored (assertion in sim).
// - rst mid-op: controller to IDLE next cycle; divider is reset by same rst.
// TESTING
// - DIVU 100/7, 64-bit -> out_data=14 at T+67; REMU -> 2.
// - DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD; REM -7/2 -> 0xFFFF_FFFF_FFFF_FFFF.
// - DIVW 0x8000_0000/-1 -> 0xFFFF_FFFF_8000_0000 at T+1, div_valid never high; REMW -> 0.
// - DIVU x/0 -> all ones at T+1; REMUW 0x1_8000_0001/0 -> 0xFFFF_FFFF_8000_0001.
// - DIVUW 0xFFFF_FFFF/1 -> 0xFFFF_FFFF_FFFF_FFFF at T+35; out_ready low 10 cycles -> held stable.
// - flush at T+20 of 64-bit op -> in_ready=0 until pulse at T+66, no out_valid; next op accepted T+67.

Source files
------------

// File: rtl/ysyx_23060136_exu_div_ctrl.sv
// ysyx_23060136_exu_div_ctrl: EXU initiator for the iterative divider, resolving div-by-zero and signed overflow locally
module ysyx_23060136_exu_div_ctrl #(
  parameter int XLEN = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic             in_word,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             div_valid,
  input  logic             div_ready,
  output logic [XLEN-1:0]  div_dividend,
  output logic [XLEN-1:0]  div_divisor,
  output logic             div_w,
  output logic             div_signed,
  input  logic             div_out_valid,
  input  logic [XLEN-1:0]  div_quotient,
  input  logic [XLEN-1:0]  div_remainder
);
  localparam logic [2:0] IDLE = 3'd0, ISSUE = 3'd1, WAIT = 3'd2, DONE = 3'd3, DRAIN = 3'd4;
  logic [2:0] state, state_n;
  logic [1:0] op;
  logic word;
  logic [XLEN-1:0] rs1, rs2, sp_res, sel;
  logic [TAG_W-1:0] tag;
  logic accept, zero, ovf, special, hs;
  function automatic logic [XLEN-1:0] sext_w(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign div_valid = state == ISSUE;
  assign accept = in_valid & in_ready & ~flush;
  assign hs = div_valid & div_ready;
  assign zero = in_word ? ~|in_rs2[31:0] : ~|in_rs2;
  assign ovf = ~in_op[0] & (in_word ? ((in_rs1[31:0] == 32'h8000_0000) & (&in_rs2[31:0]))
                                    : ((in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) & (&in_rs2)));
  assign special = zero | ovf;
  // RISC-V fixed results: x/0 = -1, x%0 = x; MIN/-1 = MIN, MIN%-1 = 0
  assign sp_res = zero ? (in_op[1] ? in_rs1 : '1) : (in_op[1] ? '0 : in_rs1);
  assign sel = op[1] ? div_remainder : div_quotient;
  assign div_dividend = rs1;
  assign div_divisor = rs2;
  assign div_w = word;
  assign div_signed = ~op[0];
  assign out_tag = tag;
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:  state_n = accept ? (special ? DONE : ISSUE) : IDLE;
      ISSUE: state_n = flush ? (hs ? DRAIN : IDLE) : (hs ? WAIT : ISSUE);
      WAIT:  state_n = div_out_valid ? (flush ? IDLE : DONE) : (flush ? DRAIN : WAIT);
      DONE:  state_n = (flush | out_ready) ? IDLE : DONE;
      DRAIN: state_n = div_out_valid ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      word <= 1'b0;
      rs1 <= '0;
      rs2 <= '0;
      tag <= '0;
      out_data <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        op <= in_op;
        word <= in_word;
        rs1 <= in_rs1;
        rs2 <= in_rs2;
        tag <= in_tag;
        if (special) out_data <= sext_w(in_word, sp_res);
      end
      if (state == WAIT && div_out_valid && !flush) out_data <= sext_w(word, sel);
    end
  end
  assert property (@(posedge clk) disable iff (rst) div_out_valid |-> (state == WAIT || state == DRAIN));
endmodule
